// File: rtl/mdio_sta.sv
// MDIO station-management master: serializes a 32-bit clause-22 frame onto mdio_out with a divided mdc,
// and captures the 16-bit read value for OP=10. Optional frame checking is enabled by MDIO_FRAME_CHECK_EN.
module mdio_sta #(
  parameter int MDC_HALF = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        err
);

  localparam int DW = (2 * MDC_HALF > 2) ? $clog2(2 * MDC_HALF) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * MDC_HALF - 1);
  localparam logic [DW-1:0] DIV_RISE = DW'(MDC_HALF - 1);
  localparam logic [DW-1:0] DIV_HI   = DW'(MDC_HALF);

  typedef enum logic [1:0] {IDLE, TX, RX, DONE} state_t;

  state_t        state_q, state_d;
  logic [4:0]    bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic [31:0]   frame_q, frame_d;
  logic [15:0]   shift_q, shift_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          mdc_q, mdc_d;
  logic          mdio_out_q, mdio_out_d;
  logic          mdio_oe_q, mdio_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          frame_ok_s;

  // Frame acceptance filter applied to the incoming request.
  always_comb begin
    frame_ok_s = 1'b1;
`ifdef MDIO_FRAME_CHECK_EN
    frame_ok_s = (t_data[31:30] == 2'b01) &&
                 ((t_data[29:28] == 2'b01) || (t_data[29:28] == 2'b10));
`else
    frame_ok_s = 1'b1;
`endif
  end

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    div_d     = div_q;
    frame_d   = frame_q;
    shift_d   = shift_q;
    rd_data_d = rd_data_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (frame_ok_s) begin
            frame_d = t_data;
            bit_d   = 5'd31;
            div_d   = '0;
            state_d = TX;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      TX, RX: begin
        // Sample the slave on the clock that raises mdc.
        if ((state_q == RX) && (div_q == DIV_RISE)) begin
          shift_d = {shift_q[14:0], mdio_in};
        end else begin
          shift_d = shift_q;
        end
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == 5'd0) begin
            state_d = DONE;
            if (frame_q[29:28] == 2'b10) begin
              rd_data_d = shift_q;
            end else begin
              rd_data_d = rd_data_q;
            end
          end else begin
            bit_d = bit_q - 5'd1;
            if ((bit_q == 5'd16) && (frame_q[29:28] == 2'b10)) begin
              state_d = RX;
            end else begin
              state_d = state_q;
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        bit_d   = 5'd31;
        div_d   = '0;
      end
      default: begin
        state_d = IDLE;
        bit_d   = 5'd31;
        div_d   = '0;
      end
    endcase

    busy_d     = (state_d == TX) || (state_d == RX);
    done_d     = (state_d == DONE);
    mdc_d      = busy_d && (div_d >= DIV_HI);
    mdio_oe_d  = (state_d == TX);
    mdio_out_d = (state_d == TX) ? frame_d[bit_d] : 1'b0;
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_q      <= 5'd31;
      div_q      <= '0;
      frame_q    <= 32'd0;
      shift_q    <= 16'd0;
      rd_data_q  <= 16'd0;
      mdc_q      <= 1'b0;
      mdio_out_q <= 1'b0;
      mdio_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      frame_q    <= frame_d;
      shift_q    <= shift_d;
      rd_data_q  <= rd_data_d;
      mdc_q      <= mdc_d;
      mdio_out_q <= mdio_out_d;
      mdio_oe_q  <= mdio_oe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mdc      = mdc_q;
  assign mdio_out = mdio_out_q;
  assign mdio_oe  = mdio_oe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mdio_sta.sv
// Self-checking bench for mdio_sta: one instance at MDC_HALF=2 and one at MDC_HALF=1,
// driven from a vector table and compared cycle by cycle against a frame-level model.
module tb_mdio_sta;

`ifdef MDIO_FRAME_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start2;
  logic [31:0] t_data;
  logic        mdio_in1, mdio_in2;
  logic        mdc1, mdio_out1, mdio_oe1, busy1, done1, err1;
  logic        mdc2, mdio_out2, mdio_oe2, busy2, done2, err2;
  logic [15:0] rd_data1, rd_data2;

  always #5 clk = ~clk;

  mdio_sta #(.MDC_HALF(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .t_data(t_data), .mdio_in(mdio_in2),
    .mdc(mdc2), .mdio_out(mdio_out2), .mdio_oe(mdio_oe2), .busy(busy2),
    .done(done2), .rd_data(rd_data2), .err(err2)
  );

  mdio_sta #(.MDC_HALF(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .t_data(t_data), .mdio_in(mdio_in1),
    .mdc(mdc1), .mdio_out(mdio_out1), .mdio_oe(mdio_oe1), .busy(busy1),
    .done(done1), .rd_data(rd_data1), .err(err1)
  );

  typedef struct {
    int          h;
    logic [31:0] frame;
    logic [15:0] slave;
    bit          hold;
    int          abort_at;
    int          exp_len;
  } vec_t;

  localparam int NV = 12;
  vec_t        vecs [0:NV-1];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_rd1 = 16'd0;
  logic [15:0] exp_rd2 = 16'd0;

  // Packed observation: {mdc, mdio_out, mdio_oe, busy, done, err, rd_data}.
  function automatic logic [21:0] obs(input int h);
    if (h == 1) return {mdc1, mdio_out1, mdio_oe1, busy1, done1, err1, rd_data1};
    else        return {mdc2, mdio_out2, mdio_oe2, busy2, done2, err2, rd_data2};
  endfunction

  // Expected lines n cycles after the accepting edge, from the frame's bit schedule.
  function automatic logic [21:0] model(input int h, input logic [31:0] f, input int n,
                                        input logic [15:0] rd_before, input logic [15:0] slv);
    int   b;
    logic rdop, oe, out, mc;
    rdop = (f[29:28] == 2'b10);
    if (n < 64 * h) begin
      b   = 31 - n / (2 * h);
      oe  = !(rdop && b <= 15);
      out = oe ? f[b] : 1'b0;
      mc  = (n % (2 * h)) >= h;
      return {mc, out, oe, 1'b1, 1'b0, 1'b0, rd_before};
    end
    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rdop ? slv : rd_before};
  endfunction

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (mdc,out,oe,busy,done,err,rd)", name, act, exp);
    end
  endtask

  task automatic set_start(input int h, input logic v);
    if (h == 1) start1 = v; else start2 = v;
  endtask

  task automatic set_in(input int h, input logic v);
    if (h == 1) mdio_in1 = v; else mdio_in2 = v;
  endtask

  task automatic run_frame(input vec_t v);
    logic [15:0] rd_before, rd_after;
    logic [21:0] o, prev;
    bit          legal;
    int          rises, done_n, b;
    rd_before = (v.h == 1) ? exp_rd1 : exp_rd2;
    legal = (v.frame[31:30] == 2'b01) && (v.frame[29:28] inside {2'b01, 2'b10});
    rises  = 0;
    done_n = -1;
    set_start(v.h, 1'b1);
    t_data = v.frame;
    @(posedge clk); #1;
    if (v.hold) t_data = 32'hFFFF_FFFF;
    else        set_start(v.h, 1'b0);
    if (CHECK_EN && !legal) begin
      set_start(v.h, 1'b0);
      check("reject_err", obs(v.h), {6'b000001, rd_before});
      @(posedge clk); #1;
      check("reject_end", obs(v.h), {6'b000000, rd_before});
      return;
    end
    prev = 22'd0;
    for (int n = 0; n <= 64 * v.h; n++) begin
      o = obs(v.h);
      check("frame", o, model(v.h, v.frame, n, rd_before, v.slave));
      if (o[21] && !prev[21]) rises++;
      if (o[17] && done_n < 0) done_n = n;
      prev = o;
      if (n == v.abort_at) begin
        rst = 1'b0;
        set_start(v.h, 1'b0);
        @(posedge clk); #1;
        check("rst_outputs", obs(v.h), 22'd0);
        check("rst_other_rd", obs(3 - v.h) & 22'h00FFFF, 22'd0);
        rst = 1'b1;
        exp_rd1 = 16'd0;
        exp_rd2 = 16'd0;
        return;
      end
      if (n < 64 * v.h) begin
        b = 31 - n / (2 * v.h);
        set_in(v.h, (b <= 15) ? v.slave[b] : 1'($urandom));
      end else begin
        set_start(v.h, 1'b0);
      end
      @(posedge clk); #1;
    end
    rd_after = (v.frame[29:28] == 2'b10) ? v.slave : rd_before;
    check("idle_after", obs(v.h), {6'b000000, rd_after});
    checks++;
    if (rises != 32) begin
      errors++;
      $display("FAIL mdc_rises actual=%0d expected=32", rises);
    end
    checks++;
    if (done_n + 1 != v.exp_len) begin
      errors++;
      $display("FAIL done_latency actual=%0d expected=%0d", done_n + 1, v.exp_len);
    end
    if (v.h == 1) exp_rd1 = rd_after; else exp_rd2 = rd_after;
  endtask

  initial begin
    vecs[0]  = '{2, 32'h508A_A5A5, 16'h0000, 1'b0, -1, 129};
    vecs[1]  = '{2, 32'h608A_0000, 16'h1234, 1'b0, -1, 129};
    vecs[2]  = '{2, 32'h508A_A5A5, 16'h0000, 1'b1, -1, 129};
    vecs[3]  = '{2, 32'h608A_0000, 16'h5A5A, 1'b0, 40, 129};
    vecs[4]  = '{2, 32'h5123_4567, 16'h0000, 1'b0, -1, 129};
    vecs[5]  = '{1, 32'h608A_0000, 16'hBEEF, 1'b0, -1, 65};
    vecs[6]  = '{2, 32'h708A_0000, 16'hFFFF, 1'b0, -1, 129};
    for (int i = 7; i < NV; i++) begin
      vecs[i].h        = ($urandom_range(1) == 0) ? 1 : 2;
      vecs[i].frame    = $urandom;
      if ($urandom_range(1) == 0) vecs[i].frame[31:28] = ($urandom_range(1) == 0) ? 4'h5 : 4'h6;
      vecs[i].slave    = 16'($urandom);
      vecs[i].hold     = 1'b0;
      vecs[i].abort_at = -1;
      vecs[i].exp_len  = 64 * vecs[i].h + 1;
    end

    rst = 1'b0; start1 = 1'b0; start2 = 1'b0; t_data = 32'd0;
    mdio_in1 = 1'b0; mdio_in2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_h2", obs(2), 22'd0);
    check("reset_h1", obs(1), 22'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      run_frame(vecs[i]);
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdio_sta.md
# mdio_sta

MDIO station-management (STA) master that sits directly upstream of the MMD slave. It takes a 32-bit management frame from the host, generates MDC from the system clock, and serializes the frame MSB-first onto mdio_out/mdio_oe. On read frames it releases the line after the turnaround field and shifts the 16-bit register value in from mdio_in, returning it to the host in parallel with a done pulse.

## Interface
- MDC_HALF, default 2: system clocks per MDC half-period (≥1); MDC frequency = clk / (2·MDC_HALF).
- clk  in  1  system clock; all logic on posedge clk.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  request; accepted only in IDLE (busy=0).
- t_data  in  32  frame {ST[31:30], OP[29:28], PHYADDR[27:23], REGADDR[22:18], TA[17:16], DATA[15:0]}, sampled on the accepting edge.
- mdio_in  in  1  serial read data from the slave.
- mdc  out  1  management clock to the slave.
- mdio_out  out  1  serial frame bit.
- mdio_oe  out  1  master drives line when 1.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.
- rd_data  out  16  captured read value; holds until next read completes.
- err  out  1  one-cycle reject pulse (MDIO_FRAME_CHECK_EN only; tied 0 otherwise).

## Operation
- Reset values: mdc=0, mdio_out=0, mdio_oe=0, busy=0, done=0, err=0, rd_data=0; state IDLE, bit counter 31, divider 0.
- States: IDLE -> TX -> (RX) -> DONE -> IDLE.
- IDLE: mdc held 0. On start=1, latch t_data, bit counter=31, divider=0, go TX; busy=1 from next cycle. start while busy ignored.
- Bit period = 2·MDC_HALF clocks: MDC_HALF clocks mdc=0, then MDC_HALF clocks mdc=1. Bit presented from start of its low half; slave samples on mdc rising edge.
- TX: mdio_oe=1, mdio_out=frame[bit]. At end of each bit period decrement counter. After bit 16: OP=10 -> RX; any other OP -> continue TX through bit 0.
- RX (bits 15..0): mdio_oe=0, mdio_out=0. In the clock where mdc goes 0->1, shift mdio_in into rd_data LSB (MSB first overall).
- After bit 0 period: DONE for one cycle: done=1, busy=0, mdc=0, mdio_oe=0; rd_data updated only for OP=10. Then IDLE; start accepted again the cycle after DONE.
- Divider and bit counter wrap/reset only at the transitions above; no free-running MDC.
- rst=0 mid-frame: next edge returns all state and outputs to reset values; partial rd_data discarded (reads 0).

## Timing
- Start accept at edge E0: first bit on lines after E0; mdc first rising at E0+MDC_HALF.
- Frame length 64·MDC_HALF clocks; done high in the cycle after the last bit period, i.e. E0+64·MDC_HALF+1 (129 for default).
- Read: mdio_oe falls at start of bit 15, E0+32·MDC_HALF+1 (stays 0 for last 32·MDC_HALF clocks).
- Back-to-back: minimum start-to-start spacing 64·MDC_HALF+2 clocks.

## Configuration
- MDIO_FRAME_CHECK_EN defined: on start, if ST≠01 or OP∉{01,10}, no frame is sent; err=1 for one cycle, busy/done stay 0, mdc stays 0, FSM stays IDLE.
- Undefined: every frame transmitted; OP≠10 handled as write; err constant 0.

## Test plan
- Write: MDC_HALF=2, t_data=0x508AA5A5 -> 32 bits on mdio_out MSB-first, mdio_oe=1 throughout, 32 mdc rising edges, done at accept+129, rd_data unchanged.
- Read: t_data=0x608A0000, slave model drives 0x1234 on bits 15..0 -> mdio_oe=0 for final 64 clocks, rd_data=0x1234 with done.
- start held 1 while busy, second t_data=0xFFFFFFFF -> ignored, first frame bits intact, one done only.
- rst=0 at clock 40 of a read -> next edge all outputs 0, rd_data=0; fresh write then completes normally.
- MDC_HALF=1 read of 0xBEEF -> mdc = clk/2, done at accept+65, rd_data=0xBEEF.
- MDIO_FRAME_CHECK_EN, t_data=0x708A0000 (OP=11) -> err pulse one cycle, no mdc edges, busy=0.
